// File: rtl/mfp_irq_pkg.sv
// mfp_irq_pkg -- shared types for the MFP-style interrupt controller.
//   state_t  : acknowledge FSM state (one bit)
//   ST_IDLE  : waiting for the CPU to raise ack
//   ST_HOLD  : ack seen and serviced; waiting for the CPU to drop it
package mfp_irq_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_HOLD = 1'b1;

endpackage

// File: rtl/mfp_prio_enc.sv
// mfp_prio_enc -- highest-set-bit encoder.
// Ports:
//   req   in  WIDTH  request vector (any number of bits may be set)
//   valid out 1      at least one request bit set
//   idx   out IW     index of the highest set bit (0 when none set)
module mfp_prio_enc #(
  parameter int WIDTH = 16,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    idx = '0;
    // Ascending scan: the last hit, i.e. the highest index, wins.
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i]) idx = IW'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/mfp_irq_ctrl.sv
// mfp_irq_ctrl -- edge-triggered interrupt controller with pending (ipr) and
// in-service (isr) registers, highest-index priority and a CPU ack handshake.
// Optional feature: define MFP_IRQ_LEVEL_EN to add level_sel, which makes the
// selected channels level-sensitive (pend every cycle irq_in == edge_sel).
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   irq_in              synchronised interrupt sources
//   edge_sel            active edge per channel (1 rising, 0 falling)
//   enable / mask       channel enable (0 clears pending) / request mask
//   pend_clr / svc_clr  write-1-to-clear strobes for ipr / isr
//   level_sel           (MFP_IRQ_LEVEL_EN only) level-sensitive channels
//   sei, ack            software end-of-interrupt mode, CPU acknowledge level
//   irq_n               registered active-low request
//   vec, ack_valid      acknowledged channel and its one-cycle strobe
//   ipr, isr            pending and in-service registers
module mfp_irq_ctrl
  import mfp_irq_pkg::*;
#(
  parameter int CHANNELS = 16,
  parameter int VW       = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] irq_in,
  input  logic [CHANNELS-1:0] edge_sel,
  input  logic [CHANNELS-1:0] enable,
  input  logic [CHANNELS-1:0] mask,
  input  logic [CHANNELS-1:0] pend_clr,
  input  logic [CHANNELS-1:0] svc_clr,
`ifdef MFP_IRQ_LEVEL_EN
  input  logic [CHANNELS-1:0] level_sel,
`endif
  input  logic                sei,
  input  logic                ack,
  output logic                irq_n,
  output logic [VW-1:0]       vec,
  output logic                ack_valid,
  output logic [CHANNELS-1:0] ipr,
  output logic [CHANNELS-1:0] isr
);

  logic [CHANNELS-1:0] irq_prev;
  logic [CHANNELS-1:0] edge_evt;
  logic [CHANNELS-1:0] evt;
  logic [CHANNELS-1:0] take_mask;
  logic [CHANNELS-1:0] ipr_next;
  logic [CHANNELS-1:0] isr_next;
  logic                p_valid, s_valid, cand_valid, take;
  logic [VW-1:0]       p_idx, s_idx;
  state_t              state;

  assign edge_evt = (edge_sel & irq_in & ~irq_prev) | (~edge_sel & ~irq_in & irq_prev);

`ifdef MFP_IRQ_LEVEL_EN
  assign evt = edge_evt | (level_sel & ~(irq_in ^ edge_sel));
`else
  assign evt = edge_evt;
`endif

  mfp_prio_enc #(.WIDTH(CHANNELS), .IW(VW)) u_pend_enc (
    .req   (ipr & mask),
    .valid (p_valid),
    .idx   (p_idx)
  );

  mfp_prio_enc #(.WIDTH(CHANNELS), .IW(VW)) u_svc_enc (
    .req   (isr),
    .valid (s_valid),
    .idx   (s_idx)
  );

  // A pending channel only interrupts if it outranks everything in service.
  assign cand_valid = p_valid && (!s_valid || (p_idx > s_idx));
  assign take       = (state == ST_IDLE) && ack;
  assign take_mask  = (take && cand_valid) ? (CHANNELS'(1) << p_idx) : '0;

  // Ack clear first, then a same-cycle event re-pends the channel, then the
  // explicit clears (pend_clr, disabled channel) override both.
  assign ipr_next = ((ipr & ~take_mask) | (evt & enable)) & ~(pend_clr | ~enable);
  assign isr_next = sei ? ((isr & ~svc_clr) | take_mask) : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // History tracks the input during reset so release creates no edge.
      irq_prev  <= irq_in;
      ipr       <= '0;
      isr       <= '0;
      vec       <= '0;
      ack_valid <= 1'b0;
      irq_n     <= 1'b1;
      state     <= ST_IDLE;
    end else begin
      irq_prev  <= irq_in;
      ipr       <= ipr_next;
      isr       <= isr_next;
      irq_n     <= ~cand_valid;
      ack_valid <= take;
      if (take) vec <= cand_valid ? p_idx : '0;
      case (state)
        ST_IDLE: if (ack)  state <= ST_HOLD;
        ST_HOLD: if (!ack) state <= ST_IDLE;
        default:           state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// tb_mfp_irq_ctrl -- directed scenarios plus randomized traffic, every cycle
// checked against a channel-by-channel behavioural model of the controller.
module tb_mfp_irq_ctrl;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] irq_in, edge_sel, enable, mask, pend_clr, svc_clr;
`ifdef MFP_IRQ_LEVEL_EN
  logic [N-1:0] level_sel;
`endif
  logic         sei, ack;
  logic         irq_n, ack_valid;
  logic [3:0]   vec;
  logic [N-1:0] ipr, isr;

  mfp_irq_ctrl #(.CHANNELS(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .irq_in    (irq_in),
    .edge_sel  (edge_sel),
    .enable    (enable),
    .mask      (mask),
    .pend_clr  (pend_clr),
    .svc_clr   (svc_clr),
`ifdef MFP_IRQ_LEVEL_EN
    .level_sel (level_sel),
`endif
    .sei       (sei),
    .ack       (ack),
    .irq_n     (irq_n),
    .vec       (vec),
    .ack_valid (ack_valid),
    .ipr       (ipr),
    .isr       (isr)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Reference model state.
  bit [N-1:0] m_ipr, m_isr, m_prev;
  bit         m_irqn, m_av, m_hold;
  int         m_vec;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  // One clock of the controller, derived channel by channel from its rules.
  task automatic model_step();
    int  top_p, top_s, cand;
    bit  take, ev, p, s;
    bit [N-1:0] n_ipr, n_isr;
    if (!reset_n) begin
      m_ipr = '0; m_isr = '0; m_vec = 0; m_av = 0; m_irqn = 1; m_hold = 0;
      m_prev = irq_in;
      return;
    end
    top_p = -1; top_s = -1;
    for (int i = 0; i < N; i++) begin
      if (m_ipr[i] && mask[i]) top_p = i;
      if (m_isr[i]) top_s = i;
    end
    cand = (top_p > top_s) ? top_p : -1;
    take = !m_hold && ack;
    for (int i = 0; i < N; i++) begin
      ev = edge_sel[i] ? (!m_prev[i] && irq_in[i]) : (m_prev[i] && !irq_in[i]);
`ifdef MFP_IRQ_LEVEL_EN
      if (level_sel[i] && (irq_in[i] == edge_sel[i])) ev = 1;
`endif
      p = m_ipr[i];
      if (take && i == cand) p = 0;
      if (ev && enable[i]) p = 1;
      if (pend_clr[i] || !enable[i]) p = 0;
      n_ipr[i] = p;
      s = m_isr[i];
      if (svc_clr[i]) s = 0;
      if (take && i == cand) s = 1;
      if (!sei) s = 0;
      n_isr[i] = s;
    end
    m_ipr  = n_ipr;
    m_isr  = n_isr;
    m_irqn = (cand < 0);
    m_av   = take;
    if (take) m_vec = (cand < 0) ? 0 : cand;
    m_hold = ack;
    m_prev = irq_in;
  endtask

  // Advance one clock, update the model, then compare away from the edge.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check("ipr", ipr, m_ipr);
    check("isr", isr, m_isr);
    check("irq_n", irq_n, m_irqn);
    check("ack_valid", ack_valid, m_av);
    check("vec", vec, m_vec);
  endtask

  task automatic idle_inputs();
    irq_in = '0; edge_sel = '1; enable = '1; mask = '1;
    pend_clr = '0; svc_clr = '0; sei = 0; ack = 0;
`ifdef MFP_IRQ_LEVEL_EN
    level_sel = '0;
`endif
  endtask

  task automatic do_reset();
    reset_n = 0;
    step(); step();
    reset_n = 1;
  endtask

  int av_count;

  initial begin
    idle_inputs();
    reset_n = 0;
    step();
    check("rst_irq_n", irq_n, 1);
    check("rst_ipr", ipr, 0);
    check("rst_ack_valid", ack_valid, 0);

    // Rising edge on ch 3.
    reset_n = 1; step();
    irq_in[3] = 1; step();
    check("ch3_ipr", ipr, 16'h0008);
    step();
    check("ch3_irq_n", irq_n, 0);

    // Simultaneous ch 2 / ch 9, then acknowledge.
    idle_inputs(); do_reset();
    irq_in[2] = 1; irq_in[9] = 1; step();
    step();
    ack = 1; step();
    check("ack9_vec", vec, 9);
    check("ack9_valid", ack_valid, 1);
    check("ack9_ipr", ipr, 16'h0004);
    ack = 0; step();
    check("ack9_irq_n", irq_n, 0);

    // Software EOI nesting.
    idle_inputs(); do_reset();
    sei = 1;
    irq_in[5] = 1; step(); step();
    ack = 1; step();
    check("sei_isr", isr, 16'h0020);
    ack = 0; step();
    irq_in[4] = 1; step(); step();
    check("sei_ch4_blocked", irq_n, 1);
    irq_in[7] = 1; step(); step();
    check("sei_ch7_irq", irq_n, 0);
    pend_clr[7] = 1; step(); pend_clr = '0; step();
    svc_clr[5] = 1; step(); svc_clr = '0; step();
    check("sei_released_isr", isr, 0);
    check("sei_released_irq", irq_n, 0);

    // Long ack: a single acknowledge only.
    idle_inputs(); do_reset();
    irq_in[1] = 1; irq_in[6] = 1; step(); step();
    ack = 1; av_count = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (ack_valid) av_count++;
    end
    ack = 0; step();
    check("hold_single_ack", av_count, 1);
    check("hold_vec", vec, 6);
    check("hold_ipr1", ipr[1], 1);

    // Clear beats event; disabled channel stays clear.
    idle_inputs(); do_reset();
    irq_in[3] = 1; pend_clr[3] = 1; step();
    check("clr_wins", ipr[3], 0);
    pend_clr = '0; irq_in[3] = 0; step();
    irq_in[3] = 1; step();
    check("clr_then_edge", ipr[3], 1);
    enable[3] = 0; step();
    irq_in[3] = 0; step(); irq_in[3] = 1; step();
    check("disabled_ipr3", ipr[3], 0);

    // Input high through reset: no spurious event; empty acknowledge.
    idle_inputs(); irq_in[0] = 1; do_reset();
    step();
    check("no_spurious", ipr, 0);
    ack = 1; step();
    check("empty_ack_valid", ack_valid, 1);
    check("empty_ack_vec", vec, 0);
    ack = 0; step();

    // Randomized traffic.
    idle_inputs(); do_reset();
    for (int k = 0; k < 3000; k++) begin
      irq_in   = irq_in ^ N'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) edge_sel[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) enable[$urandom_range(0, N-1)]   ^= 1'b1;
      if ($urandom_range(0, 15) == 0) mask[$urandom_range(0, N-1)]     ^= 1'b1;
      pend_clr = ($urandom_range(0, 7) == 0) ? (N'(1) << $urandom_range(0, N-1)) : '0;
      svc_clr  = ($urandom_range(0, 5) == 0) ? (N'(1) << $urandom_range(0, N-1)) : '0;
`ifdef MFP_IRQ_LEVEL_EN
      if ($urandom_range(0, 31) == 0) level_sel[$urandom_range(0, N-1)] ^= 1'b1;
`endif
      if ($urandom_range(0, 49) == 0) sei = ~sei;
      if ($urandom_range(0, 3) == 0)  ack = ~ack;
      reset_n = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mfp_irq_ctrl.md
MFP_IRQ_CTRL -- requirements
Module: mfp_irq_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 16, number of interrupt channels (2..32).
REQ-002 SHALL have parameter VW, default $clog2(CHANNELS), vector width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port irq_in  input  CHANNELS  raw interrupt sources, already synchronised to clk.
REQ-006 SHALL have port edge_sel  input  CHANNELS  active edge per channel: 1=rising, 0=falling.
REQ-007 SHALL have port enable  input  CHANNELS  channel enable; 0 blocks and clears pending.
REQ-008 SHALL have port mask  input  CHANNELS  request mask; 0 keeps pending but suppresses request.
REQ-009 SHALL have port pend_clr  input  CHANNELS  write-1-to-clear pending strobe.
REQ-010 SHALL have port svc_clr  input  CHANNELS  write-1-to-clear in-service strobe.
REQ-011 SHALL have port sei  input  1  software end-of-interrupt mode.
REQ-012 SHALL have port ack  input  1  CPU interrupt-acknowledge level, held by CPU for 1+ cycles.
REQ-013 SHALL have port irq_n  output  1  registered active-low interrupt request.
REQ-014 SHALL have port vec  output  VW  acknowledged channel number.
REQ-015 SHALL have port ack_valid  output  1  one-cycle strobe; vec valid.
REQ-016 SHALL have ports ipr and isr  output  CHANNELS  pending and in-service registers.

Function
REQ-017 SHALL detect an event on channel i when the previous sample differs from irq_in[i] in the direction given by edge_sel[i].
REQ-018 SHALL set ipr[i] one cycle after the event, only if enable[i]=1.
REQ-019 SHALL clear ipr[i] when pend_clr[i]=1 or enable[i]=0; a clear SHALL win over a same-cycle event.
REQ-020 SHALL give priority to the highest-index channel.
REQ-021 SHALL define the candidate as the highest i with ipr[i]&mask[i], provided i exceeds the highest set isr bit.
REQ-022 SHALL drive irq_n low one cycle after a candidate exists and high one cycle after none exists.
REQ-023 SHALL implement an FSM with states IDLE and HOLD: IDLE->HOLD on ack=1; HOLD->IDLE on ack=0; acknowledge actions occur only on the IDLE->HOLD transition.
REQ-024 On acknowledge with a candidate c, SHALL, in the same cycle, clear ipr[c], set vec=c, pulse ack_valid, and set isr[c] only if sei=1.
REQ-025 On acknowledge with no candidate, SHALL pulse ack_valid with vec=0 and change no ipr or isr bit.
REQ-026 If a new event on channel c coincides with its acknowledge, ipr[c] SHALL remain 1 so the event is not lost.
REQ-027 SHALL clear isr[i] on svc_clr[i]=1 and SHALL clear all isr bits when sei=0.
REQ-028 vec SHALL hold its value between acknowledges.

Reset
REQ-029 While reset_n=0: ipr, isr, vec and ack_valid SHALL be 0, irq_n SHALL be 1, and the FSM SHALL be in IDLE.
REQ-030 While reset_n=0, the edge-history register SHALL load irq_in, so no spurious event occurs on release.
REQ-031 Reset asserted in HOLD SHALL return the FSM to IDLE; an ack still high after release SHALL count as a new acknowledge.

Configuration
REQ-032 With MFP_IRQ_LEVEL_EN defined: SHALL add input level_sel (CHANNELS wide), and channels with level_sel[i]=1 SHALL set ipr[i] every cycle irq_in[i] equals edge_sel[i].
REQ-033 Without MFP_IRQ_LEVEL_EN: no level_sel port; all channels edge-triggered only.

Structure
REQ-034 SHALL place the FSM state type and the IDLE/HOLD encodings in package mfp_irq_pkg.
REQ-035 SHALL implement the priority selection in sub-module mfp_prio_enc (CHANNELS-wide one-hot-free highest-bit encoder with valid output).

Verification
REQ-036 Rising edge on ch 3 (edge_sel[3]=1, enable/mask=1) -> ipr=0x0008 next cycle; irq_n=0 one cycle later.
REQ-037 Edges on ch 2 and ch 9 in the same cycle, then ack pulse -> vec=9, ack_valid=1, ipr=0x0004; irq_n stays 0.
REQ-038 sei=1: ack ch 5 -> isr=0x0020; then ch 4 pending gives irq_n=1; ch 7 pending gives irq_n=0; svc_clr[5] releases ch 4.
REQ-039 ack held 5 cycles with ch 1 and ch 6 pending -> single ack_valid, vec=6, ipr[1] still 1.
REQ-040 pend_clr[3] coincident with a ch 3 edge -> ipr[3]=0; enable[3]=0 -> ipr[3] cleared and stays 0.
REQ-041 irq_in[0]=1 during reset, reset_n released -> ipr=0; ack with no candidate -> vec=0, ack_valid=1.
